// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift-type codes, FSM states and shift-count caps for the shifter operand stage
package shifter_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    // Beyond these counts further single-bit steps cannot change value or carry.
    localparam logic [5:0] LSX_CAP = 6'd33;
    localparam logic [5:0] ASR_CAP = 6'd32;

endpackage

// File: rtl/shifter_operand_seq_if.sv
// rtl/shifter_operand_seq_if.sv - request/response bundle between issuer and shifter operand stage
interface shifter_operand_seq_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] op_in;
    logic [1:0]       shift_type;
    logic [AMT_W-1:0] amount;
    logic             imm_mode;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, op_in, shift_type, amount, imm_mode, carry_in,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op_in, shift_type, amount, imm_mode, carry_in,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit step of LSL/LSR/ASR/ROR/RRX with carry-out
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             carry,
    input  logic [1:0]       typ,
    input  logic             rrx,
    output logic [WIDTH-1:0] nval,
    output logic             ncarry
);

    always_comb begin
        nval   = val;
        ncarry = carry;
        if (rrx) begin
            nval   = {carry, val[WIDTH-1:1]};
            ncarry = val[0];
        end else begin
            case (typ)
                SH_LSL: begin
                    nval   = {val[WIDTH-2:0], 1'b0};
                    ncarry = val[WIDTH-1];
                end
                SH_LSR: begin
                    nval   = {1'b0, val[WIDTH-1:1]};
                    ncarry = val[0];
                end
                SH_ASR: begin
                    nval   = {val[WIDTH-1], val[WIDTH-1:1]};
                    ncarry = val[0];
                end
                default: begin
                    nval   = {val[0], val[WIDTH-1:1]};
                    ncarry = val[0];
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_operand_seq.sv
// rtl/shifter_operand_seq.sv - iterative ARM shifter operand: one bit per cycle, start/done handshake
module shifter_operand_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic                  CLK,
    input  logic                  CLR,
    shifter_operand_seq_if.slave  bus
);

    state_e           state;
    logic [WIDTH-1:0] work;
    logic             wcarry;
    logic [5:0]       cnt;
    logic [1:0]       typ_q;
    logic             rrx_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [5:0]       n_calc;
    logic             rrx_calc;
    logic             c0_calc;
    logic [4:0]       a5;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

    assign a5 = bus.amount[4:0];

    // Zero-step cases resolve entirely through the initial working carry.
    always_comb begin
        n_calc   = '0;
        rrx_calc = 1'b0;
        c0_calc  = bus.carry_in;
        if (bus.imm_mode) begin
            case (bus.shift_type)
                SH_LSL: n_calc = {1'b0, a5};
                SH_LSR,
                SH_ASR: n_calc = (a5 == 5'd0) ? ASR_CAP : {1'b0, a5};
                default: begin
                    if (a5 == 5'd0) begin
                        n_calc   = 6'd1;
                        rrx_calc = 1'b1;
                    end else begin
                        n_calc = {1'b0, a5};
                    end
                end
            endcase
        end else if (bus.amount != '0) begin
            case (bus.shift_type)
                SH_LSL,
                SH_LSR: n_calc = (bus.amount >= AMT_W'(LSX_CAP)) ? LSX_CAP : bus.amount[5:0];
                SH_ASR: n_calc = (bus.amount >= AMT_W'(ASR_CAP)) ? ASR_CAP : bus.amount[5:0];
                default: begin
                    n_calc = {1'b0, a5};
                    if (a5 == 5'd0) c0_calc = bus.op_in[WIDTH-1];
                end
            endcase
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .val    (work),
        .carry  (wcarry),
        .typ    (typ_q),
        .rrx    (rrx_q),
        .nval   (step_val),
        .ncarry (step_c)
    );

    // Result is written on entry to DONE so it is valid in the same cycle as done.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= S_IDLE;
            work     <= '0;
            wcarry   <= 1'b0;
            cnt      <= '0;
            typ_q    <= SH_LSL;
            rrx_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work   <= bus.op_in;
                        wcarry <= c0_calc;
                        typ_q  <= bus.shift_type;
                        rrx_q  <= rrx_calc;
                        cnt    <= n_calc;
                        if (n_calc != 6'd0) begin
                            busy_q <= 1'b1;
                            state  <= S_SHIFT;
                        end else begin
                            result_q <= bus.op_in;
                            carry_q  <= c0_calc;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work   <= step_val;
                    wcarry <= step_c;
                    cnt    <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        result_q <= step_val;
                        carry_q  <= step_c;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
